// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the key/LED master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CHK,
    ST_WR_ADDR,
    ST_WR_DATA
  } master_state_t;

  // Saturating 8-bit increment used by the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ahb_key_led_master_poll_timer.sv
// Poll interval timer: counts while enabled and pulses tick on the last count.
module poll_timer #(
  parameter logic [15:0] POLL_DIV = 16'd50
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [15:0] count;

  assign tick = !clear && (count == POLL_DIV - 16'd1);

  // Counter wraps to zero on tick and is held at zero whenever clear is high.
  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/ahb_key_led_master.sv
// AHB-Lite master that polls a key register and toggles LEDs on key presses.
module ahb_key_led_master
  import ahb_pkg::*;
#(
  parameter logic [31:0] KEY_ADDR = 32'h4000_0000,
  parameter logic [31:0] LED_ADDR = 32'h4000_0004,
  parameter logic [15:0] POLL_DIV = 16'd50
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [3:0]  led_state,
  output logic [7:0]  err_cnt
);

  master_state_t state;
  master_state_t state_next;

  logic [3:0] key_prev;
  logic [3:0] key_now;
  logic [3:0] press;
  logic       poll_tick;
  logic       poll_clear;
  logic       unused_hrdata;

  assign HSIZE         = HSIZE_WORD;
  assign HBURST        = HBURST_SINGLE;
  assign HPROT         = HPROT_DATA;
  assign HMASTLOCK     = 1'b0;
  assign unused_hrdata = ^HRDATA[31:4];

  // Keys are active-low, so a press is a bit that was high and is now low.
  assign press      = key_prev & ~key_now;
  assign poll_clear = (state != ST_IDLE);

  poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_poll_timer (
    .clock(HCLK),
    .reset(HRESET),
    .clear(poll_clear),
    .tick (poll_tick)
  );

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus outputs; bus fields are zero unless a phase needs them.
  always_comb begin
    state_next = state;
    HTRANS     = HTRANS_IDLE;
    HADDR      = '0;
    HWRITE     = 1'b0;
    HWDATA     = '0;
    case (state)
      ST_IDLE: begin
        if (poll_tick) state_next = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = KEY_ADDR;
        if (HREADY) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (HREADY) state_next = HRESP ? ST_IDLE : ST_CHK;
      end
      ST_CHK: begin
        state_next = (press != 4'h0) ? ST_WR_ADDR : ST_IDLE;
      end
      ST_WR_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
        HADDR  = LED_ADDR;
        if (HREADY) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        HWDATA = {28'b0, led_state};
        if (HREADY) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Key sampling, LED toggling and error counting; a failed read leaves key_prev alone.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      key_prev  <= 4'hF;
      key_now   <= 4'hF;
      led_state <= 4'h0;
      err_cnt   <= 8'h00;
    end else begin
      case (state)
        ST_RD_DATA: begin
          if (HREADY) begin
            if (HRESP) begin
              err_cnt <= sat_inc8(err_cnt);
            end else begin
              key_now <= HRDATA[3:0];
            end
          end
        end
        ST_CHK: begin
          key_prev  <= key_now;
          led_state <= led_state ^ press;
        end
        ST_WR_DATA: begin
          if (HREADY && HRESP) err_cnt <= sat_inc8(err_cnt);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
